// File: rtl/sram64x20_arb_pkg.sv
// Shared defaults and types for the two-port arbiter in front of the 64x20 SRAM macro.
package sram64x20_arb_pkg;
   localparam int ADDR_W_DEF = 6;
   localparam int DATA_W_DEF = 20;

   typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;
   typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_id_t;
endpackage

// File: rtl/sram64x20_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, ties go to the pointer,
// and the pointer then moves to the port that lost.
module rr_arb2
   import sram64x20_arb_pkg::*;
(
   input  logic       clock,
   input  logic       reset_n,
   input  logic       en,
   input  logic [1:0] valid,
   output logic [1:0] grant
);
   port_id_t ptr;

   always_comb begin
      grant = 2'b00;
      if (en) begin
         if (valid == 2'b11) grant = (ptr == PORT0) ? 2'b01 : 2'b10;
         else                grant = valid;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n)      ptr <= PORT0;
      else if (grant[0]) ptr <= PORT1;
      else if (grant[1]) ptr <= PORT0;
   end
endmodule

// File: rtl/sram64x20_arbiter.sv
// Two-port arbiter for a 64x20 single-port SRAM macro; one access per cycle, reads return 2 edges later.
// Define SRAM64X20_ARB_INIT_CLEAR_EN to zero the whole array before accepting requests.
module sram64x20_arbiter
   import sram64x20_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
)(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              p0_req_valid,
   output logic              p0_req_ready,
   input  logic              p0_req_we,
   input  logic [ADDR_W-1:0] p0_req_addr,
   input  logic [DATA_W-1:0] p0_req_wdata,
   output logic              p0_rsp_valid,
   output logic [DATA_W-1:0] p0_rsp_rdata,
   input  logic              p1_req_valid,
   output logic              p1_req_ready,
   input  logic              p1_req_we,
   input  logic [ADDR_W-1:0] p1_req_addr,
   input  logic [DATA_W-1:0] p1_req_wdata,
   output logic              p1_rsp_valid,
   output logic [DATA_W-1:0] p1_rsp_rdata,
   output logic              sram_csb,
   output logic              sram_web,
   output logic              sram_oeb,
   output logic [ADDR_W-1:0] sram_a,
   output logic [DATA_W-1:0] sram_i,
   input  logic [DATA_W-1:0] sram_o,
   output logic              init_done
);
   state_t              state;
   logic [1:0]          grant;
   logic                arb_en;
   port_id_t            gnt_port;
   logic                gnt_we;
   logic [ADDR_W-1:0]   gnt_addr;
   logic [DATA_W-1:0]   gnt_wdata;
   logic                vld_p0;
   port_id_t            port_p0;
`ifdef SRAM64X20_ARB_INIT_CLEAR_EN
   logic [5:0]          init_cnt;
   logic                init_last;
`endif

   assign arb_en = (state == RUN);

   rr_arb2 u_arb (
      .clock   (clock),
      .reset_n (reset_n),
      .en      (arb_en),
      .valid   ({p1_req_valid, p0_req_valid}),
      .grant   (grant)
   );

   assign p0_req_ready = grant[0];
   assign p1_req_ready = grant[1];
   assign gnt_port     = grant[1] ? PORT1 : PORT0;
   assign gnt_we       = grant[1] ? p1_req_we    : p0_req_we;
   assign gnt_addr     = grant[1] ? p1_req_addr  : p0_req_addr;
   assign gnt_wdata    = grant[1] ? p1_req_wdata : p0_req_wdata;

   // Stage p0: macro pins and read tag registered at the handshake edge
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state     <= INIT;
         init_done <= 1'b0;
         sram_csb  <= 1'b1;
         sram_web  <= 1'b1;
         sram_oeb  <= 1'b1;
         sram_a    <= '0;
         sram_i    <= '0;
         vld_p0    <= 1'b0;
         p0_rsp_valid <= 1'b0;
         p1_rsp_valid <= 1'b0;
`ifdef SRAM64X20_ARB_INIT_CLEAR_EN
         init_cnt  <= '0;
         init_last <= 1'b0;
`endif
      end else begin
         sram_csb <= 1'b1;
         sram_web <= 1'b1;
         sram_oeb <= 1'b1;
         vld_p0   <= 1'b0;
         // Stage p1: macro output is valid in the cycle after it samples the read
         p0_rsp_valid <= vld_p0 && (port_p0 == PORT0);
         p1_rsp_valid <= vld_p0 && (port_p0 == PORT1);
         case (state)
            INIT: begin
`ifdef SRAM64X20_ARB_INIT_CLEAR_EN
               if (init_last) begin
                  state     <= RUN;
                  init_done <= 1'b1;
               end else begin
                  sram_csb  <= 1'b0;
                  sram_web  <= 1'b0;
                  sram_a    <= ADDR_W'(init_cnt);
                  sram_i    <= '0;
                  init_cnt  <= init_cnt + 6'd1;
                  init_last <= (init_cnt == 6'd63);
               end
`else
               state     <= RUN;
               init_done <= 1'b1;
`endif
            end
            RUN: begin
               if (|grant) begin
                  sram_csb <= 1'b0;
                  sram_a   <= gnt_addr;
                  if (gnt_we) begin
                     sram_web <= 1'b0;
                     sram_i   <= gnt_wdata;
                  end else begin
                     sram_oeb <= 1'b0;
                     vld_p0   <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (|grant) port_p0 <= gnt_port;
   end

   assign p0_rsp_rdata = p0_rsp_valid ? sram_o : '0;
   assign p1_rsp_rdata = p1_rsp_valid ? sram_o : '0;
endmodule

// File: tb/tb_sram64x20_arbiter.sv
// Randomized scoreboard bench for sram64x20_arbiter driving a behavioural SRAM macro.
// Build with +define+SRAM64X20_ARB_INIT_CLEAR_EN to cover the clear-on-init variant.
module tb_sram64x20_arbiter;
   localparam int AW = 6;
   localparam int DW = 20;
`ifdef SRAM64X20_ARB_INIT_CLEAR_EN
   localparam int INIT_LAT = 65;
`else
   localparam int INIT_LAT = 1;
`endif

   logic          clock;
   logic          reset_n;
   logic          p0_req_valid, p0_req_ready, p0_req_we, p0_rsp_valid;
   logic [AW-1:0] p0_req_addr;
   logic [DW-1:0] p0_req_wdata, p0_rsp_rdata;
   logic          p1_req_valid, p1_req_ready, p1_req_we, p1_rsp_valid;
   logic [AW-1:0] p1_req_addr;
   logic [DW-1:0] p1_req_wdata, p1_rsp_rdata;
   logic          sram_csb, sram_web, sram_oeb, init_done;
   logic [AW-1:0] sram_a;
   logic [DW-1:0] sram_i, sram_o;

   sram64x20_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clock(clock), .reset_n(reset_n),
      .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
      .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
      .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
      .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
      .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
      .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
      .sram_csb(sram_csb), .sram_web(sram_web), .sram_oeb(sram_oeb),
      .sram_a(sram_a), .sram_i(sram_i), .sram_o(sram_o),
      .init_done(init_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Behavioural macro: samples pins on the clock edge, read data registered out
   logic [DW-1:0] sram_mem [64];
   always @(posedge clock) begin
      if (!sram_csb) begin
         if (!sram_web)      sram_mem[sram_a] <= sram_i;
         else if (!sram_oeb) sram_o <= sram_mem[sram_a];
      end
   end

   typedef struct { logic [DW-1:0] data; int due; } rsp_t;
   rsp_t          q0[$], q1[$];
   rsp_t          e0, e1;
   logic [DW-1:0] ref_mem [64];
   int            ptr_m;
   int            cyc = 0;
   int            n_chk = 0;
   int            n_fail = 0;
   int            last_grant;
   logic          prev_any, prev_we;
   logic [AW-1:0] prev_addr;
   logic [DW-1:0] prev_wdata;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h required 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Response monitor: pops the expected read for whichever port presents data
   always @(negedge clock) begin
      if (p0_rsp_valid) begin
         if (q0.size() == 0) chk("p0_rsp_unexpected", 32'(p0_rsp_valid), 32'(0));
         else begin
            e0 = q0.pop_front();
            chk("p0_rsp_rdata", 32'(p0_rsp_rdata), 32'(e0.data));
            chk("p0_rsp_cycle", 32'(cyc), 32'(e0.due));
         end
      end else if (q0.size() != 0 && q0[0].due <= cyc) begin
         chk("p0_rsp_missing", 32'(p0_rsp_valid), 32'(1));
         q0.delete(0);
      end
      if (p1_rsp_valid) begin
         if (q1.size() == 0) chk("p1_rsp_unexpected", 32'(p1_rsp_valid), 32'(0));
         else begin
            e1 = q1.pop_front();
            chk("p1_rsp_rdata", 32'(p1_rsp_rdata), 32'(e1.data));
            chk("p1_rsp_cycle", 32'(cyc), 32'(e1.due));
         end
      end else if (q1.size() != 0 && q1[0].due <= cyc) begin
         chk("p1_rsp_missing", 32'(p1_rsp_valid), 32'(1));
         q1.delete(0);
      end
   end

   task automatic step(input logic v0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
      int   g;
      rsp_t e;
      @(posedge clock); #1;
      p0_req_valid = v0; p0_req_we = w0; p0_req_addr = a0; p0_req_wdata = d0;
      p1_req_valid = v1; p1_req_we = w1; p1_req_addr = a1; p1_req_wdata = d1;
      @(negedge clock);
      chk("sram_csb", 32'(sram_csb), 32'(!prev_any));
      if (prev_any) begin
         chk("sram_ctl", 32'({sram_a, sram_web, sram_oeb}), 32'({prev_addr, !prev_we, prev_we}));
         if (prev_we) chk("sram_i", 32'(sram_i), 32'(prev_wdata));
      end
      g = -1;
      if (v0 && v1) g = ptr_m;
      else if (v0)  g = 0;
      else if (v1)  g = 1;
      chk("req_ready", 32'({p1_req_ready, p0_req_ready}), (g < 0) ? 32'd0 : (g == 0) ? 32'd1 : 32'd2);
      last_grant = p1_req_ready ? 1 : (p0_req_ready ? 0 : -1);
      prev_any = (g >= 0);
      if (g >= 0) begin
         ptr_m      = 1 - g;
         prev_we    = (g == 1) ? w1 : w0;
         prev_addr  = (g == 1) ? a1 : a0;
         prev_wdata = (g == 1) ? d1 : d0;
         if (prev_we) ref_mem[prev_addr] = prev_wdata;
         else begin
            e.data = ref_mem[prev_addr];
            e.due  = cyc + 2;
            if (g == 0) q0.push_back(e);
            else        q1.push_back(e);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, '0, '0, 0, 0, '0, '0);
   endtask

   task automatic do_reset();
      int n;
      @(posedge clock); #1;
      reset_n = 1'b0;
      p0_req_valid = 1'b1; p1_req_valid = 1'b1;
      q0.delete(); q1.delete();
      ptr_m = 0; prev_any = 1'b0;
      @(posedge clock); @(negedge clock);
      chk("rst_req_ready", 32'({p1_req_ready, p0_req_ready}), 32'd0);
      chk("rst_rsp_valid", 32'({p1_rsp_valid, p0_rsp_valid}), 32'd0);
      chk("rst_rsp_rdata", 32'(p0_rsp_rdata | p1_rsp_rdata), 32'd0);
      chk("rst_sram_ctl", 32'({sram_csb, sram_web, sram_oeb}), 32'd7);
      chk("rst_sram_a_i", 32'({sram_a, sram_i}), 32'd0);
      chk("rst_init_done", 32'(init_done), 32'd0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      p0_req_valid = 1'b0; p1_req_valid = 1'b0;
      n = 0;
      while (n < 200) begin
         @(posedge clock);
         n++;
         @(negedge clock);
         if (init_done) break;
      end
      chk("init_done_latency", 32'(n), 32'(INIT_LAT));
`ifdef SRAM64X20_ARB_INIT_CLEAR_EN
      for (int k = 0; k < 64; k++) ref_mem[k] = '0;
`endif
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, actual timeout required finish");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0;
      p0_req_valid = 0; p0_req_we = 0; p0_req_addr = '0; p0_req_wdata = '0;
      p1_req_valid = 0; p1_req_we = 0; p1_req_addr = '0; p1_req_wdata = '0;
      do_reset();

      // Contention straight out of reset: p0, p1, p0, p1
      for (int k = 0; k < 4; k++) begin
         step(1, 1, AW'(k), DW'($urandom), 1, 1, AW'(k + 8), DW'($urandom));
         chk("contention_grant", 32'(last_grant), 32'(k % 2));
      end
`ifdef SRAM64X20_ARB_INIT_CLEAR_EN
      for (int k = 0; k < 4; k++) begin
         step(0, 0, '0, '0, 1, 0, AW'($urandom_range(20, 60)), '0);
      end
      idle(2);
`endif
      // Fill the array so later reads hit known contents
      for (int k = 0; k < 64; k++) step(1, 1, AW'(k), DW'($urandom), 0, 0, '0, '0);

      // Lone requester on p1, then p0 wins the next tie
      for (int k = 0; k < 3; k++) begin
         step(0, 0, '0, '0, 1, k == 1, AW'(k + 30), DW'($urandom));
         chk("lone_p1_grant", 32'(last_grant), 32'd1);
      end
      step(1, 0, 6'd5, '0, 1, 0, 6'd6, '0);
      chk("tie_after_lone", 32'(last_grant), 32'd0);

      // Single-port write then read of 0x10
      step(1, 1, 6'h10, 20'h5A5A5, 0, 0, '0, '0);
      step(1, 0, 6'h10, '0, 0, 0, '0, '0);
      idle(3);

      // Cross-port back-to-back write/read of address 63
      step(1, 1, 6'd63, 20'hFFFFF, 0, 0, '0, '0);
      step(0, 0, '0, '0, 1, 0, 6'd63, '0);
      idle(3);

      for (int k = 0; k < 400; k++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, AW'($urandom), DW'($urandom),
              $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, AW'($urandom), DW'($urandom));
      end
      idle(3);

      // Reset one cycle after a read handshake drops the response
      step(1, 0, 6'd63, '0, 0, 0, '0, '0);
      do_reset();
      idle(4);

      // Reads after the second reset (zeroes when the array is cleared on init)
      for (int k = 0; k < 40; k++) begin
         step($urandom_range(0, 1) == 1, 1'b0, AW'($urandom), '0,
              $urandom_range(0, 1) == 1, 1'b0, AW'($urandom), '0);
      end
      idle(4);
      chk("drain_queues", 32'(q0.size() + q1.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/sram64x20_arbiter.md
SRAM64X20_ARBITER -- requirements
Module: sram64x20_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 6: SRAM address width.
REQ-002 SHALL have parameter DATA_W, default 20: SRAM word width.
REQ-003 SHALL have port clock, input, 1: single clock; the SRAM macro CE pin is tied to this same clock.
REQ-004 SHALL have port reset_n, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port pN_req_valid, input, 1: request valid (N=0,1 for this and REQ-006..011).
REQ-006 SHALL have port pN_req_ready, output, 1: request accepted this cycle.
REQ-007 SHALL have port pN_req_we, input, 1: 1=write, 0=read.
REQ-008 SHALL have port pN_req_addr, input, ADDR_W: word address.
REQ-009 SHALL have port pN_req_wdata, input, DATA_W: write data.
REQ-010 SHALL have port pN_rsp_valid, output, 1: read data valid, one-cycle pulse, no backpressure.
REQ-011 SHALL have port pN_rsp_rdata, output, DATA_W: read data.
REQ-012 SHALL have ports sram_csb, sram_web, sram_oeb, outputs, 1 each: active-low macro controls.
REQ-013 SHALL have ports sram_a (output, ADDR_W), sram_i (output, DATA_W) and sram_o (input, DATA_W): macro address, write data and read data.
REQ-014 SHALL have port init_done, output, 1: high once the block accepts requests.

Function
REQ-015 SHALL implement states INIT and RUN; pN_req_ready SHALL be 0 in INIT.
REQ-016 In RUN, at most one port SHALL be granted per cycle; handshake = valid & ready at the same clock edge.
REQ-017 If exactly one port is valid, that port SHALL be granted regardless of the priority pointer.
REQ-018 If both ports are valid, the port named by a 1-bit round-robin pointer SHALL be granted.
REQ-019 After any grant, the pointer SHALL point to the non-granted port.
REQ-020 pN_req_ready SHALL depend combinationally on valids, pointer and state only, never on the other ready.
REQ-021 sram_* control outputs SHALL be registered: the cycle after a handshake, drive csb=0 with a=addr, and either web=0, oeb=1, i=wdata (write) or web=1, oeb=0 (read).
REQ-022 With no grant, the cycle after SHALL drive csb=1, web=1, oeb=1.
REQ-023 Read latency SHALL be 2 cycles: pN_rsp_valid is registered high exactly 2 edges after the read handshake, to the requesting port only.
REQ-024 pN_rsp_rdata SHALL equal sram_o while the matching rsp_valid is high.
REQ-025 Write then read of the same address on consecutive handshakes SHALL return the new data; no hazard stall is permitted.
REQ-026 Back-to-back grants every cycle SHALL be sustained (throughput 1 access/cycle).

Reset
REQ-027 While reset_n=0: all pN_req_ready=0, pN_rsp_valid=0, pN_rsp_rdata=0, sram_csb=1, sram_web=1, sram_oeb=1, sram_a=0, sram_i=0, init_done=0, pointer=port 0.
REQ-028 Reset asserted mid-operation SHALL drop in-flight responses; no rsp_valid SHALL pulse for them after reset release.

Configuration
REQ-029 Macro SRAM64X20_ARB_INIT_CLEAR_EN defined: after reset release, INIT SHALL write 0 to addresses 0..63 in order, one per cycle, using a 6-bit counter. On the cycle after the address-63 write is issued, the block SHALL enter RUN and set init_done=1.
REQ-030 Macro undefined: the block SHALL enter RUN and set init_done=1 on the first edge after reset release, with no SRAM writes.

Structure
REQ-031 A shared package sram64x20_arb_pkg SHALL hold ADDR_W/DATA_W defaults, the state enum (INIT, RUN) and the port-id type.
REQ-032 The grant logic SHALL be one sub-module rr_arb2 (2-way round-robin arbiter with pointer).

Verification
REQ-033 Single-port write/read: p0 writes 0x5A5A5 at address 0x10, then reads address 0x10 -> p0_rsp_valid 2 cycles after the read handshake with rdata 0x5A5A5, and p1_rsp_valid stays 0.
REQ-034 Contention: both ports valid for 4 cycles from reset (pointer=0) -> grants in the order p0, p1, p0, p1.
REQ-035 Lone requester: only p1 valid for 3 cycles -> p1 granted each cycle, and p0 is granted on the next simultaneous request.
REQ-036 Back-to-back access: p0 writes 0xFFFFF at address 63, then p1 reads address 63 in the following cycle -> p1 receives 0xFFFFF.
REQ-037 Init with the macro defined: init_done rises exactly 65 cycles after reset release, and reading any address returns 0x00000.
REQ-038 Reset one cycle after a read handshake -> no rsp_valid pulse, sram_csb=1 during reset.
